// File: rtl/ds_operand_unit_pkg.sv
// ---------------------------------------------------------------------------
// ds_operand_unit_pkg
//   Shared constants for the decode-side operand stage: default operand and
//   register-address widths, the hardwired-zero register index and the width
//   of one packed instruction-queue entry.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package ds_operand_unit_pkg;

   localparam int unsigned DS_DATA_W = 32;
   localparam int unsigned DS_AW     = 5;
   localparam int unsigned DS_PC_W   = 32;
   localparam int unsigned DS_INST_W = 32;

   localparam logic [DS_AW-1:0] REG_ZERO = '0;

   // Queue entry layout: {pc, inst, raddr1, raddr2, re1, re2}
   localparam int unsigned DS_ENTRY_W = DS_PC_W + DS_INST_W + 2*DS_AW + 2;

   function automatic int unsigned entry_width(input int unsigned aw);
      return DS_PC_W + DS_INST_W + 2*aw + 2;
   endfunction

endpackage

// File: rtl/ds_operand_unit_fwd_select.sv
// ---------------------------------------------------------------------------
// ds_operand_unit_fwd_select
//   Resolves one source operand against NUM_FWD prioritised forwarding
//   sources (index 0 youngest), falling back to the register file.
//   Ports:
//     addr_i       source register address
//     re_i         source is used
//     rf_data_i    register file read data for addr_i
//     fwd_valid_i  per-source "writes a register"
//     fwd_blk_i    per-source "result not yet available"
//     fwd_dest_i   packed destinations, source 0 in LSBs
//     fwd_data_i   packed results, source 0 in LSBs
//     value_o      resolved operand (don't-care when hazard_o)
//     hazard_o     youngest matching source is blocked
// ---------------------------------------------------------------------------
module ds_operand_unit_fwd_select
   import ds_operand_unit_pkg::*;
#(
   parameter int unsigned NUM_FWD = 3,
   parameter int unsigned AW      = DS_AW,
   parameter int unsigned DATA_W  = DS_DATA_W
) (
   input  logic [AW-1:0]             addr_i,
   input  logic                      re_i,
   input  logic [DATA_W-1:0]         rf_data_i,
   input  logic [NUM_FWD-1:0]        fwd_valid_i,
   input  logic [NUM_FWD-1:0]        fwd_blk_i,
   input  logic [NUM_FWD*AW-1:0]     fwd_dest_i,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
   output logic [DATA_W-1:0]         value_o,
   output logic                      hazard_o
);

   logic hit;

   always_comb begin
      value_o  = rf_data_i;
      hazard_o = 1'b0;
      hit      = 1'b0;
      if (!re_i || addr_i == AW'(REG_ZERO)) begin
         value_o = '0;
      end else begin
         // First match in ascending index order wins, so an older blocked
         // source is shadowed by a younger unblocked one.
         for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!hit && fwd_valid_i[i] && fwd_dest_i[i*AW +: AW] == addr_i) begin
               hit = 1'b1;
               if (fwd_blk_i[i]) begin
                  hazard_o = 1'b1;
               end else begin
                  value_o = fwd_data_i[i*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

endmodule

// File: rtl/ds_operand_unit.sv
// ---------------------------------------------------------------------------
// ds_operand_unit
//   Decode-side operand stage: in-order instruction queue between fetch and
//   execute, register-file read for the head entry, operand forwarding with
//   load-use stall, flush on redirect and a saturating stall-cycle counter.
//   Ports:
//     clk, reset             clock, synchronous active-high reset
//     flush                  drop all queued and incoming instructions
//     in_*                   fetch-side handshake and instruction fields
//     rf_raddr1/2, rf_rdata1/2  combinational register file read for head
//     fwd_valid/blk/dest/data   forwarding sources, index 0 youngest
//     out_*                  execute-side handshake, head fields, operands
//     occupancy              queue entry count
//     stall_cnt              saturating hazard-stall cycle count
// ---------------------------------------------------------------------------
module ds_operand_unit
   import ds_operand_unit_pkg::*;
#(
   parameter int unsigned DATA_W  = DS_DATA_W,
   parameter int unsigned AW      = DS_AW,
   parameter int unsigned NUM_FWD = 3,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_allowin,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_inst,
   input  logic [AW-1:0]              in_raddr1,
   input  logic [AW-1:0]              in_raddr2,
   input  logic                       in_re1,
   input  logic                       in_re2,
   output logic [AW-1:0]              rf_raddr1,
   output logic [AW-1:0]              rf_raddr2,
   input  logic [DATA_W-1:0]          rf_rdata1,
   input  logic [DATA_W-1:0]          rf_rdata2,
   input  logic [NUM_FWD-1:0]         fwd_valid,
   input  logic [NUM_FWD-1:0]         fwd_blk,
   input  logic [NUM_FWD*AW-1:0]      fwd_dest,
   input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
   output logic                       out_valid,
   input  logic                       out_allowin,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_inst,
   output logic [DATA_W-1:0]          out_rj_value,
   output logic [DATA_W-1:0]          out_rkd_value,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [31:0]                stall_cnt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = entry_width(AW);

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW:0]   occ_q, occ_d;
   logic [31:0]   stall_q, stall_d;

   logic [EW-1:0] entry_in, head_entry;
   logic [31:0]   head_pc, head_inst;
   logic [AW-1:0] head_ra1, head_ra2;
   logic          head_re1, head_re2;
   logic          haz1, haz2;
   logic          not_empty, push, pop;

   assign entry_in   = {in_pc, in_inst, in_raddr1, in_raddr2, in_re1, in_re2};
   assign head_entry = mem_q[rptr_q];
   assign {head_pc, head_inst, head_ra1, head_ra2, head_re1, head_re2} = head_entry;

   ds_operand_unit_fwd_select #(
      .NUM_FWD (NUM_FWD),
      .AW      (AW),
      .DATA_W  (DATA_W)
   ) u_fwd_rj (
      .addr_i      (head_ra1),
      .re_i        (head_re1),
      .rf_data_i   (rf_rdata1),
      .fwd_valid_i (fwd_valid),
      .fwd_blk_i   (fwd_blk),
      .fwd_dest_i  (fwd_dest),
      .fwd_data_i  (fwd_data),
      .value_o     (out_rj_value),
      .hazard_o    (haz1)
   );

   ds_operand_unit_fwd_select #(
      .NUM_FWD (NUM_FWD),
      .AW      (AW),
      .DATA_W  (DATA_W)
   ) u_fwd_rkd (
      .addr_i      (head_ra2),
      .re_i        (head_re2),
      .rf_data_i   (rf_rdata2),
      .fwd_valid_i (fwd_valid),
      .fwd_blk_i   (fwd_blk),
      .fwd_dest_i  (fwd_dest),
      .fwd_data_i  (fwd_data),
      .value_o     (out_rkd_value),
      .hazard_o    (haz2)
   );

   // in_allowin depends only on registered occupancy, so a pop while full
   // cannot admit a push in the same cycle.
   assign not_empty  = (occ_q != '0);
   assign in_allowin = (occ_q != (PW+1)'(DEPTH));
   assign out_valid  = not_empty && !haz1 && !haz2 && !flush;
   assign push       = in_valid && in_allowin && !flush;
   assign pop        = out_valid && out_allowin;

   assign rf_raddr1  = head_ra1;
   assign rf_raddr2  = head_ra2;
   assign out_pc     = head_pc;
   assign out_inst   = head_inst;
   assign occupancy  = occ_q;
   assign stall_cnt  = stall_q;

   always_comb begin
      rptr_d  = rptr_q + PW'(pop);
      wptr_d  = wptr_q + PW'(push);
      occ_d   = occ_q;
      stall_d = stall_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
      // Flush empties the queue by snapping the read pointer onto the write
      // pointer; push/pop are already suppressed in that cycle.
      if (flush) begin
         rptr_d = wptr_q;
         wptr_d = wptr_q;
         occ_d  = '0;
      end
      if (not_empty && (haz1 || haz2) && !flush && stall_q != '1) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         occ_q   <= '0;
         stall_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         occ_q   <= occ_d;
         stall_q <= stall_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= entry_in;
      end
   end

endmodule

// File: tb/tb_ds_operand_unit.sv
// ---------------------------------------------------------------------------
// tb_ds_operand_unit
//   Self-checking bench for ds_operand_unit: directed scenarios with literal
//   expectations plus a randomized phase, all compared every cycle against a
//   queue-based behavioural model.
// ---------------------------------------------------------------------------
module tb_ds_operand_unit;

   localparam int NF    = 3;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset, flush, in_valid, in_allowin, in_re1, in_re2;
   logic         out_valid, out_allowin;
   logic [31:0]  in_pc, in_inst, out_pc, out_inst;
   logic [31:0]  out_rj_value, out_rkd_value, stall_cnt;
   logic [31:0]  rf_rdata1, rf_rdata2;
   logic [4:0]   in_raddr1, in_raddr2, rf_raddr1, rf_raddr2;
   logic [2:0]   fwd_valid, fwd_blk;
   logic [14:0]  fwd_dest;
   logic [95:0]  fwd_data;
   logic [2:0]   occupancy;

   logic [31:0]  rf_mem [32];

   // External register file: combinational read
   assign rf_rdata1 = rf_mem[rf_raddr1];
   assign rf_rdata2 = rf_mem[rf_raddr2];

   always #5 clk = ~clk;

   ds_operand_unit #(
      .DATA_W  (32),
      .AW      (5),
      .NUM_FWD (NF),
      .DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_allowin    (in_allowin),
      .in_pc         (in_pc),
      .in_inst       (in_inst),
      .in_raddr1     (in_raddr1),
      .in_raddr2     (in_raddr2),
      .in_re1        (in_re1),
      .in_re2        (in_re2),
      .rf_raddr1     (rf_raddr1),
      .rf_raddr2     (rf_raddr2),
      .rf_rdata1     (rf_rdata1),
      .rf_rdata2     (rf_rdata2),
      .fwd_valid     (fwd_valid),
      .fwd_blk       (fwd_blk),
      .fwd_dest      (fwd_dest),
      .fwd_data      (fwd_data),
      .out_valid     (out_valid),
      .out_allowin   (out_allowin),
      .out_pc        (out_pc),
      .out_inst      (out_inst),
      .out_rj_value  (out_rj_value),
      .out_rkd_value (out_rkd_value),
      .occupancy     (occupancy),
      .stall_cnt     (stall_cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        re1;
      logic        re2;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_stall = '0;
   int          checks  = 0;
   int          errors  = 0;
   bit          chk_en  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Operand rule: unused or r0 -> 0; youngest matching forwarder decides;
   // otherwise the register file.
   function automatic void resolve(input logic [4:0] a, input logic re,
                                   output logic [31:0] v, output logic hz);
      v  = '0;
      hz = 1'b0;
      if (!re || a == 5'd0) return;
      for (int i = 0; i < NF; i++) begin
         if (fwd_valid[i] && fwd_dest[i*5 +: 5] == a) begin
            hz = fwd_blk[i];
            v  = fwd_data[i*32 +: 32];
            return;
         end
      end
      v = rf_mem[a];
   endfunction

   // Called just after a negedge with inputs set: compare, then advance the
   // model across the next posedge and return at the following negedge.
   task automatic cycle();
      logic [31:0] v1, v2;
      logic        h1, h2;
      bit          ev, eal, psh, pp, inc, rst, fl;
      ent_t        e;
      #1;
      v1 = '0; v2 = '0; h1 = 1'b0; h2 = 1'b0;
      eal = (mq.size() != DEPTH);
      ev  = 0;
      if (mq.size() > 0) begin
         resolve(mq[0].r1, mq[0].re1, v1, h1);
         resolve(mq[0].r2, mq[0].re2, v2, h2);
         ev = !h1 && !h2 && !flush;
      end
      if (chk_en) begin
         chk("in_allowin", {31'd0, in_allowin}, {31'd0, eal});
         chk("occupancy", {29'd0, occupancy}, mq.size());
         chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
         chk("stall_cnt", stall_cnt, m_stall);
         if (mq.size() > 0) begin
            chk("rf_raddr1", {27'd0, rf_raddr1}, {27'd0, mq[0].r1});
            chk("rf_raddr2", {27'd0, rf_raddr2}, {27'd0, mq[0].r2});
         end
         if (ev) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_inst", out_inst, mq[0].inst);
            chk("out_rj_value", out_rj_value, v1);
            chk("out_rkd_value", out_rkd_value, v2);
         end
      end
      psh = in_valid && eal && !flush;
      pp  = ev && out_allowin;
      inc = (mq.size() > 0) && (h1 || h2) && !flush;
      rst = reset;
      fl  = flush;
      e   = '{in_pc, in_inst, in_raddr1, in_raddr2, in_re1, in_re2};
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_stall = '0;
      end else if (fl) begin
         mq.delete();
      end else begin
         if (pp) void'(mq.pop_front());
         if (psh) mq.push_back(e);
         if (inc && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid    = 1'b0;
      flush       = 1'b0;
      out_allowin = 1'b1;
      fwd_valid   = '0;
      fwd_blk     = '0;
      fwd_dest    = '0;
      fwd_data    = '0;
      in_pc       = '0;
      in_inst     = '0;
      in_raddr1   = '0;
      in_raddr2   = '0;
      in_re1      = 1'b0;
      in_re2      = 1'b0;
   endtask

   task automatic push_set(input logic [31:0] pc, input logic [4:0] r1, input logic re1,
                           input logic [4:0] r2, input logic re2);
      in_valid  = 1'b1;
      in_pc     = pc;
      in_inst   = pc ^ 32'h5A5A_0000;
      in_raddr1 = r1;
      in_re1    = re1;
      in_raddr2 = r2;
      in_re2    = re2;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      rf_mem[5] = 32'h11;
      @(negedge clk);
      chk_en = 1;
      cycle();
      reset = 1'b0;

      // Reset state
      #1;
      chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_in_allowin", {31'd0, in_allowin}, 32'd1);
      cycle();

      // Single push, issue next cycle with regfile operand
      push_set(32'h1c00_0000, 5'd5, 1'b1, 5'd0, 1'b0);
      cycle();
      idle();
      #1;
      chk("d1_out_valid", {31'd0, out_valid}, 32'd1);
      chk("d1_rj", out_rj_value, 32'h11);
      chk("d1_pc", out_pc, 32'h1c00_0000);
      cycle();

      // Back-to-back stream of 4, one issue per cycle
      for (int k = 0; k < 5; k++) begin
         if (k < 4) push_set(32'h100 + 32'(4*k), 5'd5, 1'b1, 5'd6, 1'b1);
         else idle();
         #1;
         if (k > 0) begin
            chk("d1_stream_valid", {31'd0, out_valid}, 32'd1);
            chk("d1_stream_pc", out_pc, 32'h100 + 32'(4*(k-1)));
         end
         cycle();
      end

      // Forwarding priority
      idle();
      out_allowin = 1'b0;
      push_set(32'h140, 5'd3, 1'b1, 5'd0, 1'b0);
      cycle();
      idle();
      out_allowin = 1'b0;
      fwd_valid   = 3'b101;
      fwd_dest    = {5'd3, 5'd9, 5'd3};
      fwd_data    = {32'hBB, 32'h77, 32'hAA};
      #1;
      chk("d2_fwd0", out_rj_value, 32'hAA);
      cycle();
      fwd_valid   = 3'b100;
      out_allowin = 1'b1;
      #1;
      chk("d2_fwd2", out_rj_value, 32'hBB);
      chk("d2_valid", {31'd0, out_valid}, 32'd1);
      cycle();
      idle();

      // Load-use stall for 3 cycles, then forward 0x55
      push_set(32'h180, 5'd0, 1'b0, 5'd7, 1'b1);
      cycle();
      idle();
      fwd_valid = 3'b001;
      fwd_blk   = 3'b001;
      fwd_dest  = 15'd7;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("d3_stalled", {31'd0, out_valid}, 32'd0);
         cycle();
      end
      fwd_blk  = 3'b000;
      fwd_data = {64'd0, 32'h55};
      #1;
      chk("d3_stall_cnt", stall_cnt, 32'd3);
      chk("d3_valid", {31'd0, out_valid}, 32'd1);
      chk("d3_rkd", out_rkd_value, 32'h55);
      cycle();
      idle();

      // r0 source ignores forwarding and never stalls
      push_set(32'h1c0, 5'd0, 1'b1, 5'd0, 1'b0);
      cycle();
      idle();
      fwd_valid = 3'b001;
      fwd_blk   = 3'b001;
      fwd_dest  = 15'd0;
      fwd_data  = {64'd0, 32'hFF};
      #1;
      chk("d4_valid", {31'd0, out_valid}, 32'd1);
      chk("d4_rj_zero", out_rj_value, 32'd0);
      chk("d4_stall_cnt", stall_cnt, 32'd3);
      cycle();
      idle();

      // Fill, hold a fifth, drain through pointer wrap
      for (int k = 0; k < 4; k++) begin
         push_set(32'h200 + 32'(4*k), 5'd1, 1'b1, 5'd2, 1'b1);
         out_allowin = 1'b0;
         cycle();
      end
      push_set(32'h210, 5'd1, 1'b1, 5'd2, 1'b1);
      out_allowin = 1'b0;
      #1;
      chk("d5_full_occ", {29'd0, occupancy}, 32'd4);
      chk("d5_full_allowin", {31'd0, in_allowin}, 32'd0);
      cycle();
      out_allowin = 1'b1;
      #1;
      chk("d5_pop_pc0", out_pc, 32'h200);
      chk("d5_full_pop_allowin", {31'd0, in_allowin}, 32'd0);
      cycle();
      #1;
      chk("d5_allowin_after", {31'd0, in_allowin}, 32'd1);
      chk("d5_pop_pc1", out_pc, 32'h204);
      cycle();
      idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("d5_drain_pc", out_pc, 32'h208 + 32'(4*k));
         cycle();
      end

      // Flush with 3 queued and an incoming instruction
      for (int k = 0; k < 3; k++) begin
         push_set(32'h300 + 32'(4*k), 5'd1, 1'b1, 5'd0, 1'b0);
         out_allowin = 1'b0;
         cycle();
      end
      push_set(32'h3FC, 5'd1, 1'b1, 5'd0, 1'b0);
      flush = 1'b1;
      #1;
      chk("d6_flush_valid", {31'd0, out_valid}, 32'd0);
      cycle();
      idle();
      #1;
      chk("d6_occ", {29'd0, occupancy}, 32'd0);
      chk("d6_valid", {31'd0, out_valid}, 32'd0);
      chk("d6_stall_cnt", stall_cnt, 32'd3);
      cycle();
      cycle();

      // Randomized traffic with a mid-run reset
      for (int n = 0; n < 3000; n++) begin
         rf_mem[$urandom_range(0, 31)] = $urandom;
         reset       = (n >= 1500 && n < 1502);
         in_valid    = ($urandom_range(0, 9) < 7);
         in_pc       = $urandom;
         in_inst     = $urandom;
         in_raddr1   = 5'($urandom_range(0, 7));
         in_raddr2   = 5'($urandom_range(0, 7));
         in_re1      = ($urandom_range(0, 9) < 8);
         in_re2      = ($urandom_range(0, 9) < 8);
         out_allowin = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 99) < 3);
         for (int i = 0; i < NF; i++) begin
            fwd_valid[i]        = ($urandom_range(0, 1) == 1);
            fwd_blk[i]          = ($urandom_range(0, 3) == 0);
            fwd_dest[i*5 +: 5]  = 5'($urandom_range(0, 7));
            fwd_data[i*32 +: 32] = $urandom;
         end
         cycle();
      end
      reset = 1'b0;
      idle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ds_operand_unit.md
Name: ds_operand_unit

Overview:
- Parametrised decode-side operand stage sitting between the fetch stage and the execute stage.
- Buffers fetched instructions in a small in-order queue and reads the register file for the head entry.
- Resolves both source operands across NUM_FWD prioritised forwarding sources and stalls on load-use style hazards.
- Supports flush on redirect and counts hazard-stall cycles.

Parameters:
- DATA_W, 32, register/operand width
- AW, 5, register address width (register 0 hardwired to zero)
- NUM_FWD, 3, number of forwarding sources; index 0 is youngest (execute), highest is oldest (writeback)
- DEPTH, 4, instruction queue entries (power of two, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  redirect; discard all queued and incoming instructions
- in_valid  in  1  fetch presents an instruction
- in_allowin  out  1  queue can accept this cycle
- in_pc  in  32  instruction PC
- in_inst  in  32  instruction word
- in_raddr1  in  AW  source 1 register (rj)
- in_raddr2  in  AW  source 2 register (rk or rd)
- in_re1  in  1  source 1 is used
- in_re2  in  1  source 2 is used
- rf_raddr1  out  AW  regfile read address 1 (head entry)
- rf_raddr2  out  AW  regfile read address 2 (head entry)
- rf_rdata1  in  DATA_W  regfile data 1, combinational
- rf_rdata2  in  DATA_W  regfile data 2, combinational
- fwd_valid  in  NUM_FWD  source i holds a register-writing instruction
- fwd_blk  in  NUM_FWD  source i result not yet available (load/div in flight)
- fwd_dest  in  NUM_FWD*AW  destination of source i, packed, source 0 in LSBs
- fwd_data  in  NUM_FWD*DATA_W  result of source i, packed, source 0 in LSBs
- out_valid  out  1  head entry ready to issue
- out_allowin  in  1  execute stage accepts
- out_pc  out  32  head PC
- out_inst  out  32  head instruction
- out_rj_value  out  DATA_W  resolved operand 1
- out_rkd_value  out  DATA_W  resolved operand 2
- occupancy  out  clog2(DEPTH)+1  queue entry count
- stall_cnt  out  32  saturating hazard-stall cycle counter

Behaviour:
- Reset: queue empty, read/write pointers 0, occupancy 0, out_valid 0, stall_cnt 0. in_allowin is 1 the cycle after reset deasserts.
- Queue: circular buffer with wrapping pointers.
  - push = in_valid && in_allowin && !flush.
  - pop = out_valid && out_allowin.
  - Simultaneous push and pop leaves occupancy unchanged; both pointers advance.
- in_allowin = occupancy != DEPTH, from registered state only; no combinational path from out_allowin. When full, a same-cycle pop does not enable a push.
- Head read: rf_raddr1/2 = head raddr1/2, combinational from registered head. When the queue is empty they carry the stale head; rf_* values are don't-care.
- Operand resolution, per source s with address a and enable re:
  - If !re or a==0: value 0, no hazard.
  - Otherwise select the lowest index i with fwd_valid[i] && fwd_dest[i]==a.
  - If such an i exists and fwd_blk[i]: hazard.
  - If such an i exists and !fwd_blk[i]: value = fwd_data[i].
  - If no match: value = rf_rdataN.
  - A blocked older source never causes a hazard when a younger source matches unblocked.
- Issue: out_valid = occupancy!=0 && !hazard1 && !hazard2 && !flush.
- Latency: an entry pushed in cycle T can issue in T+1 at the earliest (zero-bubble back-to-back).
- flush: at the next edge occupancy=0 and rptr=wptr. A push and pop in the flush cycle are ignored. out_valid is 0 during the flush cycle.
- stall_cnt: +1 each cycle with occupancy!=0 && (hazard1||hazard2) && !flush; saturates at 2^32-1; not cleared by flush.
- Reset mid-operation: all state cleared regardless of flush or in_valid.

Decomposition:
- Shared package: AW, DATA_W, register-zero constant, packed queue-entry width (32+32+2*AW+2).
- One sub-module: fwd_select, instantiated twice (one per source). Parametrised by NUM_FWD/AW/DATA_W; takes addr/re/rf_data plus the fwd buses and returns value and hazard.

Test Plan:
- Push pc 0x1c000000 with raddr1=5 (regfile r5=0x11) and no forwarding, out_allowin=1 -> out_valid at T+1, out_rj_value=0x11; a stream of 4 then issues one per cycle.
- Head raddr1=3; fwd0 dest3 data 0xAA and fwd2 dest3 data 0xBB, both valid, unblocked -> out_rj_value=0xAA. Drop fwd0 -> 0xBB.
- Head raddr2=7, fwd0 valid+blk dest 7 for 3 cycles -> out_valid=0 for 3 cycles, stall_cnt=3; clearing blk with data 0x55 -> issue with out_rkd_value=0x55.
- raddr1=0, re1=1, fwd0 dest0 data 0xFF -> out_rj_value=0, no stall.
- out_allowin=0, push 4 -> occupancy=4, in_allowin=0; fifth in_valid held is not taken until a pop; after releasing, order is preserved through pointer wrap.
- Queue holds 3, flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, the flushed-cycle instruction is never issued, stall_cnt unchanged.
